// File: rtl/alu_pkg.sv
// Shared ALU op codes and the issue-controller state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    function automatic logic is_mul(input logic [2:0] op);
        return op == ALU_MUL;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Execute-stage ALU issue controller: accepts one op, holds operands for the
// op latency, captures the ALU result and hands it downstream.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_WIDTH   = 5,
    parameter int MUL_LATENCY = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [DATA_WIDTH-1:0] InSrcA,
    input  logic [DATA_WIDTH-1:0] InSrcB,
    input  logic [2:0]            InALUControl,
    input  logic [TAG_WIDTH-1:0]  InTag,
    output logic [DATA_WIDTH-1:0] SrcA,
    output logic [DATA_WIDTH-1:0] SrcB,
    output logic [2:0]            ALUControl,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic                  Zero,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] OutResult,
    output logic                  OutZero,
    output logic [TAG_WIDTH-1:0]  OutTag,
    output logic                  Busy
);

    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [TAG_WIDTH-1:0] tag;
    logic               accept;
    logic               capture;
    logic               release_out;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        InReady     = 1'b0;
        Busy        = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            ST_IDLE: begin
                InReady = 1'b1;
                if (InValid) begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                Busy = 1'b1;
                if (cnt == '0) begin
                    capture    = 1'b1;
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                Busy    = 1'b1;
                InReady = OutReady;
                if (OutReady) begin
                    release_out = 1'b1;
                    // Handoff and new accept share one edge, so no bubble.
                    next_state  = InValid ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        accept = InValid && InReady;
    end

    // Operands only move on accept, keeping the MUL multicycle path legal.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            SrcA       <= '0;
            SrcB       <= '0;
            ALUControl <= '0;
            tag        <= '0;
            cnt        <= '0;
        end else if (accept) begin
            SrcA       <= InSrcA;
            SrcB       <= InSrcB;
            ALUControl <= InALUControl;
            tag        <= InTag;
            cnt        <= is_mul(InALUControl) ? CNT_W'(MUL_LATENCY - 1) : '0;
        end else if (state == ST_EXEC && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OutValid  <= 1'b0;
            OutResult <= '0;
            OutZero   <= 1'b0;
            OutTag    <= '0;
        end else if (capture) begin
            OutValid  <= 1'b1;
            OutResult <= ALUResult;
            OutZero   <= Zero;
            OutTag    <= tag;
        end else if (release_out) begin
            OutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU between the
// operand outputs and the result inputs.
module tb_alu_issue_ctrl;

    localparam int DW = 32;
    localparam int TW = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [DW-1:0] InSrcA = '0;
    logic [DW-1:0] InSrcB = '0;
    logic [2:0]    InALUControl = '0;
    logic [TW-1:0] InTag = '0;
    logic [DW-1:0] SrcA;
    logic [DW-1:0] SrcB;
    logic [2:0]    ALUControl;
    logic [DW-1:0] ALUResult;
    logic          Zero;
    logic          OutValid;
    logic          OutReady = 1'b0;
    logic [DW-1:0] OutResult;
    logic          OutZero;
    logic [TW-1:0] OutTag;
    logic          Busy;

    int passed = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    alu_issue_ctrl #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .MUL_LATENCY(4)) dut (
        .CLK(CLK), .RST(RST),
        .InValid(InValid), .InReady(InReady),
        .InSrcA(InSrcA), .InSrcB(InSrcB), .InALUControl(InALUControl), .InTag(InTag),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
        .ALUResult(ALUResult), .Zero(Zero),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutResult(OutResult), .OutZero(OutZero), .OutTag(OutTag),
        .Busy(Busy)
    );

    // Behavioural ALU; unlisted codes return 0 with Zero low.
    always_comb begin
        logic known;
        known     = 1'b1;
        ALUResult = '0;
        case (ALUControl)
            3'b000: ALUResult = SrcA & SrcB;
            3'b001: ALUResult = SrcA | SrcB;
            3'b010: ALUResult = SrcA + SrcB;
            3'b100: ALUResult = SrcA - SrcB;
            3'b101: ALUResult = SrcA * SrcB;
            3'b110: ALUResult = ($signed(SrcA) < $signed(SrcB)) ? 32'd1 : 32'd0;
            default: known = 1'b0;
        endcase
        Zero = known && (ALUResult == '0);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [TW-1:0] t);
        InValid      = 1'b1;
        InALUControl = op;
        InSrcA       = a;
        InSrcB       = b;
        InTag        = t;
    endtask

    task automatic test_reset();
        #1;
        total++; if ({SrcA, SrcB, ALUControl, OutResult, OutZero, OutTag, OutValid} !== '0)
            $display("FAIL reset_regs: got nonzero outputs, expected all 0"); else passed++;
        total++; if (Busy !== 1'b0 || InReady !== 1'b1)
            $display("FAIL reset_state: Busy=%b InReady=%b expected 0/1", Busy, InReady); else passed++;
        step();
        RST = 1'b1;
        step();
        drive(3'b101, 32'd7, 32'd6, 5'd1);
        step();
        InValid = 1'b0;
        step();
        #3 RST = 1'b0;
        #1;
        total++; if ({SrcA, SrcB, ALUControl, OutResult, OutZero, OutTag, OutValid} !== '0)
            $display("FAIL async_reset: outputs nonzero mid-op, expected all 0"); else passed++;
        total++; if (Busy !== 1'b0 || InReady !== 1'b1)
            $display("FAIL async_reset_state: Busy=%b InReady=%b expected 0/1", Busy, InReady); else passed++;
        step();
        RST = 1'b1;
        OutReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++; if (OutValid !== 1'b0)
                $display("FAIL discarded_op: OutValid=%b at cycle %0d, expected 0", OutValid, i); else passed++;
        end
    endtask

    task automatic test_add();
        OutReady = 1'b1;
        drive(3'b010, 32'd5, 32'd3, 5'd2);
        #1;
        total++; if (InReady !== 1'b1)
            $display("FAIL add_ready_idle: InReady=%b expected 1", InReady); else passed++;
        step();
        InValid = 1'b0;
        total++; if (OutValid !== 1'b0 || InReady !== 1'b0 || Busy !== 1'b1)
            $display("FAIL add_exec: OutValid=%b InReady=%b Busy=%b expected 0/0/1", OutValid, InReady, Busy); else passed++;
        step();
        total++; if (OutValid !== 1'b1 || OutResult !== 32'd8 || OutTag !== 5'd2 || OutZero !== 1'b0)
            $display("FAIL add_result: v=%b r=%0d tag=%0d z=%b expected 1/8/2/0", OutValid, OutResult, OutTag, OutZero); else passed++;
        total++; if (InReady !== 1'b1)
            $display("FAIL add_ready_hold: InReady=%b expected 1", InReady); else passed++;
        step();
        total++; if (OutValid !== 1'b0 || Busy !== 1'b0)
            $display("FAIL add_release: OutValid=%b Busy=%b expected 0/0", OutValid, Busy); else passed++;
        drive(3'b000, 32'hF0, 32'h0F, 5'd6);
        step();
        InValid = 1'b0;
        step();
        total++; if (OutValid !== 1'b1 || OutResult !== 32'd0 || OutZero !== 1'b1 || OutTag !== 5'd6)
            $display("FAIL and_zero: v=%b r=%0h z=%b tag=%0d expected 1/0/1/6", OutValid, OutResult, OutZero, OutTag); else passed++;
        step();
    endtask

    task automatic test_mul();
        OutReady = 1'b1;
        drive(3'b101, 32'd7, 32'd6, 5'd3);
        step();
        InValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++; if (OutValid !== 1'b0 || SrcA !== 32'd7 || SrcB !== 32'd6 || ALUControl !== 3'b101)
                $display("FAIL mul_hold_%0d: v=%b A=%0d B=%0d op=%b expected 0/7/6/101", k, OutValid, SrcA, SrcB, ALUControl); else passed++;
            step();
        end
        total++; if (OutValid !== 1'b1 || OutResult !== 32'd42 || OutTag !== 5'd3)
            $display("FAIL mul_result: v=%b r=%0d tag=%0d expected 1/42/3", OutValid, OutResult, OutTag); else passed++;
        step();
    endtask

    task automatic test_backpressure();
        OutReady = 1'b0;
        drive(3'b100, 32'd10, 32'd4, 5'd4);
        step();
        InValid = 1'b0;
        step();
        drive(3'b001, 32'hF0, 32'h0F, 5'd5);
        for (int k = 0; k < 5; k++) begin
            total++; if (OutValid !== 1'b1 || OutResult !== 32'd6 || OutTag !== 5'd4 || InReady !== 1'b0 || SrcA !== 32'd10)
                $display("FAIL bp_hold_%0d: v=%b r=%0d tag=%0d rdy=%b A=%0d expected 1/6/4/0/10", k, OutValid, OutResult, OutTag, InReady, SrcA); else passed++;
            step();
        end
        OutReady = 1'b1;
        #1;
        total++; if (InReady !== 1'b1)
            $display("FAIL bp_ready: InReady=%b expected 1", InReady); else passed++;
        step();
        InValid = 1'b0;
        total++; if (OutValid !== 1'b0 || SrcA !== 32'hF0 || ALUControl !== 3'b001 || Busy !== 1'b1)
            $display("FAIL bp_handoff: v=%b A=%0h op=%b busy=%b expected 0/f0/001/1", OutValid, SrcA, ALUControl, Busy); else passed++;
        step();
        total++; if (OutValid !== 1'b1 || OutResult !== 32'hFF || OutTag !== 5'd5)
            $display("FAIL bp_or_result: v=%b r=%0h tag=%0d expected 1/ff/5", OutValid, OutResult, OutTag); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] va [8];
        logic [DW-1:0] vb [8];
        logic [DW-1:0] exp_r [8];
        va = '{32'd3, 32'd9, 32'hFFFFFFFF, 32'd2, 32'd5, 32'd0, 32'hFFFFFFF8, 32'd7};
        vb = '{32'd9, 32'd3, 32'd2, 32'hFFFFFFFF, 32'd5, 32'd1, 32'hFFFFFFF9, 32'hFFFFFFF8};
        exp_r = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'd0};
        OutReady = 1'b1;
        drive(3'b110, va[0], vb[0], 5'd10);
        for (int i = 0; i < 8; i++) begin
            step();
            total++; if (OutValid !== 1'b0 || SrcA !== va[i])
                $display("FAIL stream_accept_%0d: v=%b A=%0h expected 0/%0h", i, OutValid, SrcA, va[i]); else passed++;
            if (i < 7) drive(3'b110, va[i+1], vb[i+1], TW'(11 + i));
            else InValid = 1'b0;
            step();
            total++; if (OutValid !== 1'b1 || OutResult !== exp_r[i] || OutTag !== TW'(10 + i))
                $display("FAIL stream_result_%0d: v=%b r=%0d tag=%0d expected 1/%0d/%0d", i, OutValid, OutResult, OutTag, exp_r[i], 10 + i); else passed++;
        end
        step();
        total++; if (OutValid !== 1'b0 || Busy !== 1'b0)
            $display("FAIL stream_drain: v=%b busy=%b expected 0/0", OutValid, Busy); else passed++;
    endtask

    task automatic test_illegal_op();
        OutReady = 1'b1;
        drive(3'b111, 32'd1, 32'd1, 5'd9);
        step();
        InValid = 1'b0;
        total++; if (OutValid !== 1'b0 || ALUControl !== 3'b111)
            $display("FAIL illegal_accept: v=%b op=%b expected 0/111", OutValid, ALUControl); else passed++;
        step();
        total++; if (OutValid !== 1'b1 || OutResult !== 32'd0 || OutZero !== 1'b0 || OutTag !== 5'd9)
            $display("FAIL illegal_result: v=%b r=%0d z=%b tag=%0d expected 1/0/0/9", OutValid, OutResult, OutZero, OutTag); else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_illegal_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
